// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline-register sequencer.
// Optional perf counters in pipeline_ctrl are enabled by PIPELINE_PERF_CNT_EN.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the IF_ID instruction and a load in ID_EX.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  output logic       hazard
);

  // x0 never carries a real dependency, so a load targeting it cannot stall.
  assign hazard = ex_is_load && (ex_rd != REG_ZERO) &&
                  ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                   (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline-register sequencer: load-use stalls, EX redirect flushes, halt/drain/resume.
// Define PIPELINE_PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_redirect,
  input  logic        halt_req,
  input  logic        resume_req,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_nop,
  output logic        id_ex_we,
  output logic        id_ex_nop,
  output logic        ex_mem_nop,
  output logic        halted,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  // Control handshake: every output is a level for the current cycle; a we/nop pair
  // is never both high, and we=0 with nop=0 means the register holds.

  state_t     state, state_d;
  logic [1:0] bubble_cnt, bubble_d;
  logic [2:0] drain_cnt, drain_d;
  logic       hazard;

  load_use_detect u_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .hazard      (hazard)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      bubble_cnt <= 2'd0;
      drain_cnt  <= 3'd0;
    end else begin
      state      <= state_d;
      bubble_cnt <= bubble_d;
      drain_cnt  <= drain_d;
    end
  end

  always_comb begin
    state_d    = state;
    bubble_d   = bubble_cnt;
    drain_d    = drain_cnt;
    pc_we      = 1'b1;
    if_id_we   = 1'b1;
    if_id_nop  = 1'b0;
    id_ex_we   = 1'b1;
    id_ex_nop  = 1'b0;
    ex_mem_nop = 1'b0;
    halted     = 1'b0;
    if (ex_redirect && (state != HALTED)) begin
      // Redirect wins over any stall: load the target, squash the two younger slots.
      if_id_we  = 1'b0;
      if_id_nop = 1'b1;
      id_ex_we  = 1'b0;
      id_ex_nop = 1'b1;
      if (state == LD_STALL) begin
        state_d  = RUN;
        bubble_d = 2'd0;
      end else if (state == DRAIN) begin
        drain_d = 3'(DRAIN_CYCLES);
      end
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            id_ex_nop = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              state_d  = LD_STALL;
              bubble_d = 2'(LOAD_BUBBLES - 1);
            end
          end else if (halt_req) begin
            state_d = DRAIN;
            drain_d = 3'(DRAIN_CYCLES);
          end
        end
        LD_STALL: begin
          pc_we     = 1'b0;
          if_id_we  = 1'b0;
          id_ex_we  = 1'b0;
          id_ex_nop = 1'b1;
          bubble_d  = bubble_cnt - 2'd1;
          if (bubble_cnt <= 2'd1) state_d = RUN;
        end
        DRAIN: begin
          pc_we     = 1'b0;
          if_id_we  = 1'b0;
          if_id_nop = 1'b1;
          drain_d   = drain_cnt - 3'd1;
          if (drain_cnt <= 3'd1) state_d = HALTED;
        end
        default: begin
          pc_we      = 1'b0;
          if_id_we   = 1'b0;
          if_id_nop  = 1'b1;
          id_ex_we   = 1'b0;
          id_ex_nop  = 1'b1;
          ex_mem_nop = 1'b1;
          halted     = 1'b1;
          if (resume_req) state_d = RUN;
        end
      endcase
    end
    // While reset is held the pipeline free-runs regardless of hazard inputs.
    if (!rst_n) begin
      pc_we      = 1'b1;
      if_id_we   = 1'b1;
      if_id_nop  = 1'b0;
      id_ex_we   = 1'b1;
      id_ex_nop  = 1'b0;
      ex_mem_nop = 1'b0;
      halted     = 1'b0;
    end
  end

`ifdef PIPELINE_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;
  logic        stall_inc, flush_inc;

  assign stall_inc = !ex_redirect && ((state == LD_STALL) || ((state == RUN) && hazard));
  assign flush_inc = ex_redirect && (state != HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (stall_inc) stall_q <= stall_q + 32'd1;
      if (flush_inc) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = 32'b0;
  assign flush_events = 32'b0;
`endif

endmodule
